riscv_mprf: RTL and testbench

RISCV_MPRF -- requirements
Module: riscv_mprf

---
 rtl/riscv_rf_pkg.sv | 10 +
 rtl/riscv_rf_rdport.sv | 39 +++
 rtl/riscv_mprf.sv | 129 ++++++++++++
 tb/tb_riscv_mprf.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
// Shared types and constants for the multi-port register file.
package riscv_rf_pkg;

  typedef enum logic {INIT, RUN} rf_state_e;

  function automatic int unsigned rf_depth(input int unsigned ar_bits);
    return 32'd1 << ar_bits;
  endfunction

endpackage

// File: rtl/riscv_rf_rdport.sv
// One registered read port: x0 detect, same-cycle write forwarding, output register.
module riscv_rf_rdport
  import riscv_rf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5,
  parameter int NWR     = 2,
  parameter int BYPASS  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  input  logic [AR_BITS-1:0] addr,
  input  logic [XLEN-1:0]    arr_data,
  input  logic [NWR-1:0]     wr_en,
  input  logic [AR_BITS-1:0] wr_addr [NWR],
  input  logic [XLEN-1:0]    wr_data [NWR],
  output logic [XLEN-1:0]    rd_data
);

  logic [XLEN-1:0] rd_nxt;

  // Write ports are ordered by priority, so the last match wins.
  always_comb begin
    rd_nxt = arr_data;
    if (BYPASS != 0) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p] == addr)) rd_nxt = wr_data[p];
      end
    end
    if (!run || (addr == '0)) rd_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data <= '0;
    else       rd_data <= rd_nxt;
  end

endmodule

// File: rtl/riscv_mprf.sv
// Multi-port RISC-V integer register file with debug access and a
// post-reset clear sequence that zeroes every entry.
module riscv_mprf
  import riscv_rf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5,
  parameter int RDPORTS = 2,
  parameter int WRPORTS = 1,
  parameter int BYPASS  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [AR_BITS-1:0] rf_src1  [RDPORTS],
  input  logic [AR_BITS-1:0] rf_src2  [RDPORTS],
  output logic [XLEN-1:0]    rf_srcv1 [RDPORTS],
  output logic [XLEN-1:0]    rf_srcv2 [RDPORTS],
  input  logic [AR_BITS-1:0] rf_dst   [WRPORTS],
  input  logic [XLEN-1:0]    rf_dstv  [WRPORTS],
  input  logic [WRPORTS-1:0] rf_we,
  input  logic               du_stall,
  input  logic               du_we_rf,
  input  logic               du_re_rf,
  input  logic [11:0]        du_addr,
  input  logic [XLEN-1:0]    du_dato,
  output logic [XLEN-1:0]    du_dati_rf,
  output logic               du_ack,
  output logic               init_busy
);

  localparam int DEPTH = rf_depth(AR_BITS);
  localparam int NWR   = WRPORTS + 1;

  logic [XLEN-1:0]    mem [DEPTH];
  rf_state_e          state, state_nxt;
  logic [AR_BITS-1:0] idx, idx_nxt;
  logic               run;
  logic               dbg_acc, dbg_we, dbg_re;
  logic [AR_BITS-1:0] dbg_reg;
  logic               du_addr_unused;
  logic [NWR-1:0]     wr_en;
  logic [AR_BITS-1:0] wr_addr [NWR];
  logic [XLEN-1:0]    wr_data [NWR];
  logic [XLEN-1:0]    dbg_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    init_busy = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        idx_nxt   = idx + 1'b1;
        if (idx == {AR_BITS{1'b1}}) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  assign run            = (state == RUN);
  assign dbg_acc        = run & du_stall;
  assign dbg_we         = dbg_acc & du_we_rf;
  assign dbg_re         = dbg_acc & du_re_rf;
  assign dbg_reg        = du_addr[AR_BITS-1:0];
  assign du_addr_unused = ^du_addr[11:AR_BITS];

  // The debug write occupies the top (highest-priority) slot and masks core writes.
  always_comb begin
    for (int p = 0; p < WRPORTS; p++) begin
      wr_en[p]   = run && !dbg_we && rf_we[p] && (rf_dst[p] != '0);
      wr_addr[p] = rf_dst[p];
      wr_data[p] = rf_dstv[p];
    end
    wr_en[WRPORTS]   = dbg_we && (dbg_reg != '0);
    wr_addr[WRPORTS] = dbg_reg;
    wr_data[WRPORTS] = du_dato;
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[idx] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  for (genvar i = 0; i < RDPORTS; i++) begin : g_rd
    riscv_rf_rdport #(.XLEN(XLEN), .AR_BITS(AR_BITS), .NWR(NWR), .BYPASS(BYPASS)) u_rd1 (
      .clk(clk), .rstn(rstn), .run(run), .addr(rf_src1[i]), .arr_data(mem[rf_src1[i]]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rf_srcv1[i])
    );
    riscv_rf_rdport #(.XLEN(XLEN), .AR_BITS(AR_BITS), .NWR(NWR), .BYPASS(BYPASS)) u_rd2 (
      .clk(clk), .rstn(rstn), .run(run), .addr(rf_src2[i]), .arr_data(mem[rf_src2[i]]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rf_srcv2[i])
    );
  end

  // Debug reads always see a same-cycle write, independent of BYPASS.
  always_comb begin
    dbg_rd = mem[dbg_reg];
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p] == dbg_reg)) dbg_rd = wr_data[p];
    end
    if (dbg_reg == '0) dbg_rd = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      du_dati_rf <= '0;
      du_ack     <= 1'b0;
    end else begin
      du_ack <= dbg_acc & (du_we_rf | du_re_rf);
      if (dbg_re) du_dati_rf <= dbg_rd;
    end
  end

endmodule

// File: tb/tb_riscv_mprf.sv
// Directed bench: a 32-entry dual-write-port bypassing instance and a
// 16-entry single-port read-first instance share clock and reset.
module tb_riscv_mprf;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  logic [4:0]  src1 [2], src2 [2], dst [2];
  logic [31:0] srcv1 [2], srcv2 [2], dstv [2];
  logic [1:0]  we;
  logic        du_stall, du_we_rf, du_re_rf, du_ack, init_busy;
  logic [11:0] du_addr;
  logic [31:0] du_dato, du_dati_rf;

  logic [3:0]  e_src1 [1], e_src2 [1], e_dst [1];
  logic [31:0] e_srcv1 [1], e_srcv2 [1], e_dstv [1];
  logic [0:0]  e_we;
  logic        e_stall, e_we_rf, e_re_rf, e_ack, e_busy;
  logic [11:0] e_addr;
  logic [31:0] e_dato, e_dati;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  d0;
    logic [31:0] v0;
    logic [4:0]  d1;
    logic [31:0] v1;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  riscv_mprf #(.XLEN(32), .AR_BITS(5), .RDPORTS(2), .WRPORTS(2), .BYPASS(1)) dut (
    .clk(clk), .rstn(rstn),
    .rf_src1(src1), .rf_src2(src2), .rf_srcv1(srcv1), .rf_srcv2(srcv2),
    .rf_dst(dst), .rf_dstv(dstv), .rf_we(we),
    .du_stall(du_stall), .du_we_rf(du_we_rf), .du_re_rf(du_re_rf),
    .du_addr(du_addr), .du_dato(du_dato), .du_dati_rf(du_dati_rf),
    .du_ack(du_ack), .init_busy(init_busy)
  );

  riscv_mprf #(.XLEN(32), .AR_BITS(4), .RDPORTS(1), .WRPORTS(1), .BYPASS(0)) dut_e (
    .clk(clk), .rstn(rstn),
    .rf_src1(e_src1), .rf_src2(e_src2), .rf_srcv1(e_srcv1), .rf_srcv2(e_srcv2),
    .rf_dst(e_dst), .rf_dstv(e_dstv), .rf_we(e_we),
    .du_stall(e_stall), .du_we_rf(e_we_rf), .du_re_rf(e_re_rf),
    .du_addr(e_addr), .du_dato(e_dato), .du_dati_rf(e_dati),
    .du_ack(e_ack), .init_busy(e_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 2'b00; dst[0] = '0; dst[1] = '0; dstv[0] = '0; dstv[1] = '0;
    du_stall = 1'b0; du_we_rf = 1'b0; du_re_rf = 1'b0; du_addr = '0; du_dato = '0;
    e_we = 1'b0; e_dst[0] = '0; e_dstv[0] = '0;
    e_stall = 1'b0; e_we_rf = 1'b0; e_re_rf = 1'b0; e_addr = '0; e_dato = '0;
  endtask

  // Counts edges until each instance leaves its clear sequence; main-instance
  // outputs must stay quiet on every sample taken while it was clearing.
  task automatic wait_init(output int na, output int nb, output int noisy);
    int cnt = 0;
    na = -1; nb = -1; noisy = 0;
    while ((init_busy || e_busy) && cnt < 200) begin
      tick();
      cnt++;
      if (na < 0 && (srcv1[0] != 0 || du_ack || du_dati_rf != 0)) noisy++;
      if (na < 0 && !init_busy) na = cnt;
      if (nb < 0 && !e_busy) nb = cnt;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    we = v.we; dst[0] = v.d0; dstv[0] = v.v0; dst[1] = v.d1; dstv[1] = v.v1;
    src1[0] = v.ra; src2[1] = v.ra;
    tick();
    check_output("vec srcv1[0]", srcv1[0], v.exp);
    check_output("vec srcv2[1]", srcv2[1], v.exp);
  endtask

  initial begin
    int na, nb, noisy;

    vecs[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF};
    vecs[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  32'hDEADBEEF};
    vecs[2]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       5'd7,  32'h22};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  32'h22};
    vecs[4]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd0,  32'h0};
    vecs[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  32'h0};
    vecs[6]  = '{2'b10, 5'd0,  32'h0,        5'd9,  32'h12345678, 5'd9,  32'h12345678};
    vecs[7]  = '{2'b01, 5'd9,  32'hCAFEF00D, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF};
    vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  32'hCAFEF00D};
    vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 32'h0};
    vecs[10] = '{2'b11, 5'd31, 32'hAAAA0000, 5'd30, 32'h5555,     5'd31, 32'hAAAA0000};
    vecs[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd30, 32'h5555};

    idle();
    src1[0] = '0; src1[1] = '0; src2[0] = '0; src2[1] = '0;
    e_src1[0] = '0; e_src2[0] = '0;

    // Reset state, then a clear sequence with core and debug traffic that must be ignored.
    #2 rstn = 1'b0;
    #10;
    check_output("reset init_busy", 32'(init_busy), 32'd1);
    check_output("reset srcv1[0]", srcv1[0], 32'h0);
    check_output("reset du_dati_rf", du_dati_rf, 32'h0);
    check_output("reset du_ack", 32'(du_ack), 32'd0);

    we = 2'b01; dst[0] = 5'd4; dstv[0] = 32'h77; src1[0] = 5'd4;
    du_stall = 1'b1; du_we_rf = 1'b1; du_re_rf = 1'b1; du_addr = 12'd6; du_dato = 32'h99;
    @(posedge clk); #1 rstn = 1'b1;
    wait_init(na, nb, noisy);
    idle();
    check_output("init cycles main", 32'(na), 32'd32);
    check_output("init cycles rv32e", 32'(nb), 32'd16);
    check_output("init quiet outputs", 32'(noisy), 32'd0);

    for (int a = 0; a < 32; a++) begin
      src1[0] = 5'(a);
      tick();
      check_output($sformatf("cleared x%0d", a), srcv1[0], 32'h0);
    end

    for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);
    idle();

    // Debug write beats a same-cycle core write to the same register.
    du_stall = 1'b1; du_we_rf = 1'b1; du_addr = 12'd3; du_dato = 32'hA5A5A5A5;
    we = 2'b01; dst[0] = 5'd3; dstv[0] = 32'h1; src1[0] = 5'd3;
    tick();
    check_output("dbg wr ack", 32'(du_ack), 32'd1);
    check_output("dbg wr bypass", srcv1[0], 32'hA5A5A5A5);
    idle();
    tick();
    check_output("dbg ack one cycle", 32'(du_ack), 32'd0);
    check_output("dbg wr array", srcv1[0], 32'hA5A5A5A5);

    du_we_rf = 1'b1; du_addr = 12'd3; du_dato = 32'h0BAD;
    tick();
    check_output("unstalled wr no ack", 32'(du_ack), 32'd0);
    check_output("unstalled wr no bypass", srcv1[0], 32'hA5A5A5A5);
    idle();
    tick();
    check_output("unstalled wr ignored", srcv1[0], 32'hA5A5A5A5);

    du_stall = 1'b1; du_re_rf = 1'b1; du_addr = 12'd5;
    tick();
    check_output("dbg rd data", du_dati_rf, 32'hDEADBEEF);
    check_output("dbg rd ack", 32'(du_ack), 32'd1);
    idle();
    tick();
    check_output("dbg rd hold", du_dati_rf, 32'hDEADBEEF);
    check_output("dbg rd ack drop", 32'(du_ack), 32'd0);

    du_stall = 1'b1; du_re_rf = 1'b1; du_addr = 12'd0;
    tick();
    check_output("dbg rd x0", du_dati_rf, 32'h0);

    du_we_rf = 1'b1; du_addr = 12'd8; du_dato = 32'h13572468;
    tick();
    check_output("dbg wr+rd data", du_dati_rf, 32'h13572468);
    check_output("dbg wr+rd ack", 32'(du_ack), 32'd1);
    idle();
    src1[0] = 5'd8;
    tick();
    check_output("dbg wr+rd array", srcv1[0], 32'h13572468);

    du_stall = 1'b1; du_re_rf = 1'b1; du_addr = 12'd10;
    we = 2'b01; dst[0] = 5'd10; dstv[0] = 32'hBEEF0001;
    tick();
    check_output("dbg rd core bypass", du_dati_rf, 32'hBEEF0001);
    idle();
    du_re_rf = 1'b1; du_addr = 12'd5;
    tick();
    check_output("unstalled rd no ack", 32'(du_ack), 32'd0);
    check_output("unstalled rd hold", du_dati_rf, 32'hBEEF0001);
    idle();

    // Asynchronous reset in RUN while outputs are live.
    du_stall = 1'b1; du_re_rf = 1'b1; du_addr = 12'd5; src1[0] = 5'd5;
    tick();
    rstn = 1'b0;
    #1;
    idle();
    check_output("run reset srcv1[0]", srcv1[0], 32'h0);
    check_output("run reset du_dati_rf", du_dati_rf, 32'h0);
    check_output("run reset du_ack", 32'(du_ack), 32'd0);
    check_output("run reset init_busy", 32'(init_busy), 32'd1);
    tick();
    rstn = 1'b1;
    wait_init(na, nb, noisy);
    check_output("run reset init cycles", 32'(na), 32'd32);
    tick();
    check_output("run reset x5 cleared", srcv1[0], 32'h0);

    // Reset at clear index 10 must restart the full sequence.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_output("mid init busy", 32'(init_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_output("mid init reset busy", 32'(init_busy), 32'd1);
    check_output("mid init reset srcv1[0]", srcv1[0], 32'h0);
    tick();
    rstn = 1'b1;
    wait_init(na, nb, noisy);
    check_output("mid init restart cycles", 32'(na), 32'd32);
    check_output("mid init restart rv32e", 32'(nb), 32'd16);

    // RV32E instance: read-first behaviour and 12-bit debug address decode.
    e_we = 1'b1; e_dst[0] = 4'd5; e_dstv[0] = 32'hDEADBEEF; e_src1[0] = 4'd5;
    tick();
    check_output("e read-first", e_srcv1[0], 32'h0);
    e_we = 1'b0;
    tick();
    check_output("e write landed", e_srcv1[0], 32'hDEADBEEF);

    e_stall = 1'b1; e_we_rf = 1'b1; e_addr = 12'h013; e_dato = 32'h33333333; e_src2[0] = 4'd3;
    tick();
    check_output("e dbg ack", 32'(e_ack), 32'd1);
    check_output("e dbg wr read-first", e_srcv2[0], 32'h0);
    idle();
    tick();
    check_output("e dbg wr x3", e_srcv2[0], 32'h33333333);
    e_stall = 1'b1; e_re_rf = 1'b1; e_addr = 12'h003;
    tick();
    check_output("e dbg rd x3", e_dati, 32'h33333333);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
